// File: rtl/ones4_sched_if.sv
// Bundle of requester-side and result signals for the shared ones-mod-4 scheduler.
// The master drives requests, words and clears; the slave (scheduler) returns grants and results.
interface ones4_sched_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(W + 1);

    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   clr;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           done;
    logic [IW-1:0]  done_id;
    logic [HW-1:0]  hits;
    logic           a_o;
    logic           b_o;
    logic [2*N-1:0] ctx_o;

    modport master (
        output req, data, clr,
        input  gnt, busy, done, done_id, hits, a_o, b_o, ctx_o
    );

    modport slave (
        input  req, data, clr,
        output gnt, busy, done, done_id, hits, a_o, b_o, ctx_o
    );
endinterface

// File: rtl/ones4_sched.sv
// Round-robin scheduler time-sharing one serial ones-mod-4 detector among N requesters.
// Each requester owns a 2-bit detector context; granted words stream LSB-first on falling edges of ck.
module ones4_sched #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic          ck,
    input  logic          rst_n,
    ones4_sched_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(W + 1);
    localparam int XW = $clog2(W);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    // Detector step: returns {b, d1, d0} for state s and input bit a.
    function automatic logic [2:0] det_step(input logic [1:0] s, input logic a);
        det_step = {a & s[1] & s[0], s[1] ^ (a & s[0]), s[0] ^ a};
    endfunction

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic [XW-1:0]   idx_q, idx_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [1:0]      ws_q, ws_d;
    logic [HW-1:0]   acc_q, acc_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [IW-1:0]   done_id_q, done_id_d;
    logic [HW-1:0]   hits_q, hits_d;
    logic [2*N-1:0]  ctx_q, ctx_d;

    logic            found_s;
    logic [IW-1:0]   pick_s;
    logic            last_s;
    logic            a_s;
    logic            b_s;
    logic [1:0]      ws_nxt_s;

    assign last_s = (idx_q == XW'(W - 1));

    // Round-robin search starting just after the last served requester.
    always_comb begin
        logic [IW-1:0] c;
        found_s = 1'b0;
        pick_s  = '0;
        c       = rr_q;
        for (int k = 0; k < N; k++) begin
            c = (c == IW'(N - 1)) ? IW'(0) : c + IW'(1);
            if (!found_s && bus.req[c]) begin
                found_s = 1'b1;
                pick_s  = c;
            end else begin
                found_s = found_s;
            end
        end
    end

    // FSM state register.
    always_ff @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found_s) state_d = SHIFT; else state_d = IDLE;
            SHIFT:   if (last_s)  state_d = IDLE;  else state_d = SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: serial bit into the shared detector and its hit.
    always_comb begin
        logic [2:0] step_v;
        if (state_q == SHIFT) begin
            a_s = shreg_q[0];
        end else begin
            a_s = 1'b0;
        end
        step_v   = det_step(ws_q, a_s);
        b_s      = step_v[2];
        ws_nxt_s = step_v[1:0];
    end

    // Datapath next-state: grant load, serial shift, write-back and clears.
    always_comb begin
        rr_d      = rr_q;
        cur_d     = cur_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        ws_d      = ws_q;
        acc_d     = acc_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        hits_d    = hits_q;
        ctx_d     = ctx_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    shreg_d = bus.data[pick_s*W +: W];
                    ws_d    = ctx_q[2*pick_s +: 2];
                    cur_d   = pick_s;
                    rr_d    = pick_s;
                    gnt_d   = ONE_N << pick_s;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    acc_d   = '0;
                end else begin
                    gnt_d = '0;
                end
            end
            SHIFT: begin
                ws_d    = ws_nxt_s;
                acc_d   = acc_q + HW'(b_s);
                shreg_d = shreg_q >> 1;
                idx_d   = idx_q + XW'(1);
                if (last_s) begin
                    ctx_d[2*cur_q +: 2] = ws_nxt_s;
                    hits_d              = acc_q + HW'(b_s);
                    done_id_d           = cur_q;
                    done_d              = 1'b1;
                    gnt_d               = '0;
                    busy_d              = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
        // A clear on the write-back edge takes precedence over the write-back.
        for (int j = 0; j < N; j++) begin
            if (bus.clr[j]) begin
                ctx_d[2*j +: 2] = 2'b00;
            end else begin
                ctx_d[2*j +: 2] = ctx_d[2*j +: 2];
            end
        end
    end

    // Datapath registers.
    always_ff @(negedge ck or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= IW'(N - 1);
            cur_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            ws_q      <= 2'b00;
            acc_q     <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            hits_q    <= '0;
            ctx_q     <= '0;
        end else begin
            rr_q      <= rr_d;
            cur_q     <= cur_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            ws_q      <= ws_d;
            acc_q     <= acc_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            hits_q    <= hits_d;
            ctx_q     <= ctx_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.hits    = hits_q;
    assign bus.a_o     = a_s;
    assign bus.b_o     = b_s;
    assign bus.ctx_o   = ctx_q;
endmodule

// File: tb/tb_ones4_sched.sv
// Self-checking bench for ones4_sched: directed vector table, corner sequences,
// and randomized traffic checked against a popcount-based reference model.
module tb_ones4_sched;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;
    localparam int HW = 4;

    logic ck = 1'b0;
    logic rst_n;
    always #5 ck = ~ck;

    ones4_sched_if #(.N(N), .W(W)) bus();
    ones4_sched #(.N(N), .W(W)) dut (.ck(ck), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         id;
        logic [7:0] word;
        bit         pre_clr;
        int         exp_hits;
        int         exp_ctx;
        logic [7:0] exp_bpat;
    } vec_t;
    vec_t tab[7];

    // Reference model state (counts of ones mod 4 per requester).
    bit         m_busy, m_done;
    int         m_cnt, m_cur, m_rr, m_wctx, m_hits, m_did;
    int         m_ctx[N];
    logic [W-1:0] m_word;

    task automatic step();
        @(negedge ck);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int popc(input logic [W-1:0] w);
        int c = 0;
        for (int i = 0; i < W; i++) c += int'(w[i]);
        return c;
    endfunction

    function automatic logic [2*N-1:0] pack_ctx();
        logic [2*N-1:0] v = '0;
        for (int j = 0; j < N; j++) v[2*j +: 2] = 2'(m_ctx[j]);
        return v;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_cur = 0; m_rr = N - 1;
        m_wctx = 0; m_hits = 0; m_did = 0; m_word = '0;
        for (int j = 0; j < N; j++) m_ctx[j] = 0;
    endtask

    // One falling edge of the model using the inputs currently on the bus.
    task automatic model_edge();
        bit found = 1'b0;
        int c = m_rr;
        int tot;
        m_done = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                c = (c + 1) % N;
                if (!found && bus.req[c]) begin
                    found = 1'b1;
                    m_cur = c;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_word = bus.data[m_cur*W +: W];
                m_wctx = m_ctx[m_cur];
                m_cnt  = 0;
                m_rr   = m_cur;
            end
        end else begin
            m_cnt++;
            if (m_cnt == W) begin
                tot           = m_wctx + popc(m_word);
                m_hits        = tot / 4;
                m_ctx[m_cur]  = tot % 4;
                m_did         = m_cur;
                m_done        = 1'b1;
                m_busy        = 1'b0;
            end
        end
        for (int j = 0; j < N; j++) if (bus.clr[j]) m_ctx[j] = 0;
    endtask

    initial begin
        logic [N-1:0] first_gnt, prev_gnt;
        int g_cyc[$];
        int g_id[$];
        int viol, lat, ones;
        bit g, dn, saw_done;
        logic [7:0] bpat, mask;
        logic [N-1:0] oh;
        logic exp_a, exp_b;

        tab[0] = '{0, 8'hFF, 1'b0, 2, 0, 8'h88};
        tab[1] = '{0, 8'h07, 1'b0, 0, 3, 8'h00};
        tab[2] = '{0, 8'h01, 1'b0, 1, 0, 8'h01};
        tab[3] = '{1, 8'h07, 1'b0, 0, 3, 8'h00};
        tab[4] = '{1, 8'h01, 1'b1, 0, 1, 8'h00};
        tab[5] = '{2, 8'h0F, 1'b0, 1, 0, 8'h08};
        tab[6] = '{3, 8'hAA, 1'b0, 1, 0, 8'h80};

        // Reset with all requests held.
        rst_n = 1'b0; bus.req = 4'hF; bus.data = '0; bus.clr = 4'h0;
        step(); step();
        chk("rst_gnt", bus.gnt, 4'h0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_hits", bus.hits, 4'h0);
        chk("rst_ctx", bus.ctx_o, 8'h00);
        chk("rst_a", bus.a_o, 1'b0);

        // Round-robin with every requester held high.
        rst_n = 1'b1;
        viol = 0; prev_gnt = '0; first_gnt = '0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (k == 0) first_gnt = bus.gnt;
            if ($countones(bus.gnt) > 1) viol++;
            if (bus.gnt != 4'h0 && bus.gnt != prev_gnt) begin
                g_cyc.push_back(cyc);
                for (int i = 0; i < N; i++) if (bus.gnt[i]) g_id.push_back(i);
            end
            prev_gnt = bus.gnt;
        end
        chk("first_gnt", first_gnt, 4'b0001);
        chk("rr_onehot_viol", viol, 0);
        chk("rr_grant_count_ge5", (g_id.size() >= 5), 1'b1);
        for (int i = 0; i < 5 && i < g_id.size(); i++) begin
            chk("rr_order", g_id[i], i % N);
            if (i > 0) chk("rr_spacing", g_cyc[i] - g_cyc[i-1], W + 1);
        end
        bus.req = 4'h0;
        dn = 1'b0;
        for (int k = 0; k < 20 && !dn; k++) begin
            step();
            if (!bus.busy) dn = 1'b1;
        end
        chk("rr_drain", dn, 1'b1);
        step();

        // Directed single-word table.
        for (int t = 0; t < 7; t++) begin
            if (tab[t].pre_clr) begin
                bus.clr = 4'h1 << tab[t].id;
                step();
                bus.clr = 4'h0;
            end
            bus.data = '0;
            bus.data[tab[t].id*W +: W] = tab[t].word;
            bus.req = 4'h1 << tab[t].id;
            g = 1'b0;
            for (int k = 0; k < 5 && !g; k++) begin
                step();
                if (bus.gnt != 4'h0) g = 1'b1;
            end
            chk("tab_gnt", bus.gnt, 4'h1 << tab[t].id);
            bus.req = 4'h0;
            bpat = 8'h00; lat = 0; dn = 1'b0;
            for (int k = 0; k < 20 && !dn; k++) begin
                if (k < W) bpat[k] = bus.b_o;
                step();
                lat++;
                if (bus.done) dn = 1'b1;
            end
            chk("tab_done_latency", lat, W);
            chk("tab_done_id", bus.done_id, tab[t].id);
            chk("tab_hits", bus.hits, tab[t].exp_hits);
            chk("tab_bpat", bpat, tab[t].exp_bpat);
            chk("tab_ctx", bus.ctx_o[2*tab[t].id +: 2], tab[t].exp_ctx);
            step();
            chk("tab_done_clear", bus.done, 1'b0);
        end

        // Clear coinciding with requester 2's write-back edge.
        bus.data = '0;
        bus.data[2*W +: W] = 8'h3F;
        bus.req = 4'b0100;
        step();
        chk("clrwb_gnt", bus.gnt, 4'b0100);
        bus.req = 4'h0;
        for (int k = 0; k < W - 1; k++) step();
        chk("clrwb_not_done_yet", bus.done, 1'b0);
        bus.clr = 4'b0100;
        step();
        bus.clr = 4'h0;
        chk("clrwb_done", bus.done, 1'b1);
        chk("clrwb_id", bus.done_id, 2);
        chk("clrwb_hits", bus.hits, 1);
        chk("clrwb_ctx2", bus.ctx_o[5:4], 2'b00);
        chk("clrwb_ctx1", bus.ctx_o[3:2], 2'b01);
        step();

        // Reset while requester 3 is on bit 4.
        bus.data = '0;
        bus.data[3*W +: W] = 8'hFF;
        bus.req = 4'b1000;
        step();
        chk("rstmid_gnt", bus.gnt, 4'b1000);
        bus.req = 4'h0;
        for (int k = 0; k < 4; k++) step();
        rst_n = 1'b0;
        #1;
        chk("rstmid_gnt0", bus.gnt, 4'h0);
        chk("rstmid_busy0", bus.busy, 1'b0);
        chk("rstmid_ctx0", bus.ctx_o, 8'h00);
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (bus.done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.done) saw_done = 1'b1;
        end
        chk("rstmid_no_done", saw_done, 1'b0);
        chk("rstmid_ctx_after", bus.ctx_o, 8'h00);

        // Randomized traffic against the reference model.
        rst_n = 1'b0; bus.req = 4'h0; bus.clr = 4'h0;
        step();
        rst_n = 1'b1;
        model_reset();
        for (int t = 0; t < 600; t++) begin
            bus.req  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            bus.data = $urandom;
            bus.clr  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            model_edge();
            step();
            oh = m_busy ? (4'h1 << m_cur) : 4'h0;
            chk("rnd_gnt", bus.gnt, oh);
            chk("rnd_busy", bus.busy, m_busy);
            chk("rnd_done", bus.done, m_done);
            chk("rnd_ctx", bus.ctx_o, pack_ctx());
            if (m_done) begin
                chk("rnd_hits", bus.hits, m_hits);
                chk("rnd_done_id", bus.done_id, m_did);
            end
            exp_a = m_busy ? m_word[m_cnt] : 1'b0;
            mask  = (8'h01 << m_cnt) - 8'h01;
            ones  = m_wctx + popc(m_word & mask);
            exp_b = exp_a && ((ones % 4) == 3);
            chk("rnd_a_o", bus.a_o, exp_a);
            chk("rnd_b_o", bus.b_o, exp_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
